// File: rtl/route_gate_rx.sv
// Receive-side route capability gate: per-port table of permitted sender IDs,
// one registered grant/deny response per request, saturating telemetry counters.
module route_gate_rx #(
   parameter int unsigned N_PORTS    = 4,
   parameter int unsigned N_ENTRIES  = 4,
   parameter int unsigned UL_ID_BITS = 4,
   parameter int unsigned CNT_BITS   = 16,
   localparam int unsigned PORT_BITS = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  ctrl_valid,
   output logic                  ctrl_ready,
   input  logic [1:0]            ctrl_op,
   input  logic [PORT_BITS-1:0]  ctrl_port,
   input  logic [UL_ID_BITS-1:0] ctrl_ul_id,
   output logic                  ctrl_err,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [PORT_BITS-1:0]  req_port,
   input  logic [UL_ID_BITS-1:0] req_ul_id,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [PORT_BITS-1:0]  rsp_port,
   output logic                  rsp_grant,
   output logic [CNT_BITS-1:0]   grant_cnt,
   output logic [CNT_BITS-1:0]   deny_cnt
);

   localparam logic [1:0] OP_ADD      = 2'b00;
   localparam logic [1:0] OP_DEL      = 2'b01;
   localparam logic [1:0] OP_CLR_PORT = 2'b10;
   localparam logic [1:0] OP_CLR_ALL  = 2'b11;
   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

   logic [N_ENTRIES-1:0]  tbl_valid [N_PORTS];
   logic [UL_ID_BITS-1:0] tbl_id    [N_PORTS][N_ENTRIES];

   logic                  ctrl_fire;
   logic                  req_fire;
   logic                  ctrl_in_range;
   logic                  req_in_range;
   logic [PORT_BITS-1:0]  ctrl_row;
   logic [PORT_BITS-1:0]  req_row;
   logic [N_ENTRIES-1:0]  ctrl_hit;
   logic [N_ENTRIES-1:0]  req_hit;
   logic [N_ENTRIES-1:0]  ctrl_free;
   logic [N_ENTRIES-1:0]  ctrl_pick;
   logic                  grant_c;
   logic                  err_c;
   logic                  do_add;

   assign ctrl_fire     = ctrl_valid & ctrl_ready;
   assign req_ready     = ctrl_ready & (~rsp_valid | rsp_ready);
   assign req_fire      = req_valid & req_ready;
   assign ctrl_in_range = 32'(ctrl_port) < N_PORTS;
   assign req_in_range  = 32'(req_port) < N_PORTS;
   assign ctrl_row      = ctrl_in_range ? ctrl_port : '0;
   assign req_row       = req_in_range ? req_port : '0;

   // Parallel compare of every slot in the addressed row
   always_comb begin
      ctrl_hit = '0;
      req_hit  = '0;
      for (int unsigned e = 0; e < N_ENTRIES; e++) begin
         ctrl_hit[e] = tbl_valid[ctrl_row][e] && (tbl_id[ctrl_row][e] == ctrl_ul_id);
         req_hit[e]  = tbl_valid[req_row][e] && (tbl_id[req_row][e] == req_ul_id);
      end
   end

   // Lowest-index free slot as a one-hot
   assign ctrl_free = ~tbl_valid[ctrl_row];
   assign ctrl_pick = ctrl_free & (~ctrl_free + N_ENTRIES'(1));
   assign grant_c   = req_in_range & (|req_hit);

   always_comb begin
      err_c  = 1'b0;
      do_add = 1'b0;
      case (ctrl_op)
         OP_ADD: begin
            err_c  = ~ctrl_in_range | ((ctrl_hit == '0) & (ctrl_free == '0));
            do_add = ctrl_fire & ctrl_in_range & (ctrl_hit == '0) & (ctrl_free != '0);
         end
         OP_DEL:      err_c = ~ctrl_in_range | (ctrl_hit == '0);
         OP_CLR_PORT: err_c = ~ctrl_in_range;
         default:     err_c = 1'b0;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int unsigned p = 0; p < N_PORTS; p++) tbl_valid[p] <= '0;
      end else if (ctrl_fire) begin
         case (ctrl_op)
            OP_ADD: if (do_add) tbl_valid[ctrl_row] <= tbl_valid[ctrl_row] | ctrl_pick;
            OP_DEL: if (ctrl_in_range) tbl_valid[ctrl_row] <= tbl_valid[ctrl_row] & ~ctrl_hit;
            OP_CLR_PORT: if (ctrl_in_range) tbl_valid[ctrl_row] <= '0;
            OP_CLR_ALL: for (int unsigned p = 0; p < N_PORTS; p++) tbl_valid[p] <= '0;
            default: ;
         endcase
      end
   end

   // ID storage is qualified by the valid bits, so it carries no reset
   always_ff @(posedge aclk) begin
      if (do_add) begin
         for (int unsigned e = 0; e < N_ENTRIES; e++)
            if (ctrl_pick[e]) tbl_id[ctrl_row][e] <= ctrl_ul_id;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ctrl_ready <= 1'b0;
         ctrl_err   <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_port   <= '0;
         rsp_grant  <= 1'b0;
         grant_cnt  <= '0;
         deny_cnt   <= '0;
      end else begin
         ctrl_ready <= 1'b1;
         ctrl_err   <= ctrl_fire & err_c;
         if (req_fire) begin
            rsp_valid <= 1'b1;
            rsp_port  <= req_port;
            rsp_grant <= grant_c;
            if (grant_c && grant_cnt != CNT_MAX) grant_cnt <= grant_cnt + CNT_BITS'(1);
            if (!grant_c && deny_cnt != CNT_MAX) deny_cnt <= deny_cnt + CNT_BITS'(1);
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_route_gate_rx.sv
// Bench for route_gate_rx: set-based permission model, directed scenarios with
// literal expectations, then randomized traffic with occasional resets.
module tb_route_gate_rx;
   localparam int unsigned NP  = 4;
   localparam int unsigned NE  = 4;
   localparam int unsigned IDB = 4;
   localparam int unsigned CB  = 4;
   localparam int unsigned PB  = 2;
   localparam int CMAX = (1 << CB) - 1;
   localparam logic [1:0] ADD = 2'b00, DEL = 2'b01, CLRP = 2'b10, CLRA = 2'b11;

   logic           aclk = 1'b0;
   logic           aresetn = 1'b0;
   logic           ctrl_valid = 1'b0;
   logic           ctrl_ready;
   logic [1:0]     ctrl_op = 2'b00;
   logic [PB-1:0]  ctrl_port = '0;
   logic [IDB-1:0] ctrl_ul_id = '0;
   logic           ctrl_err;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [PB-1:0]  req_port = '0;
   logic [IDB-1:0] req_ul_id = '0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b0;
   logic [PB-1:0]  rsp_port;
   logic           rsp_grant;
   logic [CB-1:0]  grant_cnt;
   logic [CB-1:0]  deny_cnt;

   route_gate_rx #(.N_PORTS(NP), .N_ENTRIES(NE), .UL_ID_BITS(IDB), .CNT_BITS(CB)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready), .ctrl_op(ctrl_op),
      .ctrl_port(ctrl_port), .ctrl_ul_id(ctrl_ul_id), .ctrl_err(ctrl_err),
      .req_valid(req_valid), .req_ready(req_ready), .req_port(req_port),
      .req_ul_id(req_ul_id), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_port(rsp_port), .rsp_grant(rsp_grant),
      .grant_cnt(grant_cnt), .deny_cnt(deny_cnt)
   );

   always #5 aclk = ~aclk;

   int n_vec = 0;
   int n_bad = 0;

   // Model: each port row is a set of permitted IDs with a capacity of NE
   bit m_rdy, m_rsp_v, m_grant, m_err;
   int m_port, m_gc, m_dc;
   bit mem [NP][1 << IDB];
   int occ [NP];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_rdy = 0; m_rsp_v = 0; m_grant = 0; m_err = 0;
      m_port = 0; m_gc = 0; m_dc = 0;
      for (int p = 0; p < int'(NP); p++) begin
         occ[p] = 0;
         for (int i = 0; i < (1 << IDB); i++) mem[p][i] = 0;
      end
   endtask

   task automatic chk_regs();
      chk("ctrl_ready", 32'(ctrl_ready), 32'(m_rdy));
      chk("ctrl_err",   32'(ctrl_err),   32'(m_err));
      chk("rsp_valid",  32'(rsp_valid),  32'(m_rsp_v));
      chk("rsp_port",   32'(rsp_port),   32'(m_port));
      chk("rsp_grant",  32'(rsp_grant),  32'(m_grant));
      chk("grant_cnt",  32'(grant_cnt),  32'(m_gc));
      chk("deny_cnt",   32'(deny_cnt),   32'(m_dc));
   endtask

   // One clock: apply inputs, check the combinational ready, advance the model, check registers
   task automatic cyc(input bit cv, input logic [1:0] op, input int cp, input int cid,
                      input bit rv, input int rp, input int rid, input bit rr);
      bit cf, rf, g, e;
      ctrl_valid = cv; ctrl_op = op; ctrl_port = PB'(cp); ctrl_ul_id = IDB'(cid);
      req_valid = rv; req_port = PB'(rp); req_ul_id = IDB'(rid); rsp_ready = rr;
      #1;
      chk("req_ready", 32'(req_ready), 32'(m_rdy && (!m_rsp_v || rr)));
      cf = cv && m_rdy;
      rf = rv && m_rdy && (!m_rsp_v || rr);
      g  = (rp < int'(NP)) && mem[rp][rid];
      e  = 0;
      if (cf) begin
         if (op == CLRA) begin
            for (int p = 0; p < int'(NP); p++) begin
               occ[p] = 0;
               for (int i = 0; i < (1 << IDB); i++) mem[p][i] = 0;
            end
         end else if (cp >= int'(NP)) begin
            e = 1;
         end else if (op == ADD) begin
            if (!mem[cp][cid]) begin
               if (occ[cp] == int'(NE)) e = 1;
               else begin mem[cp][cid] = 1; occ[cp]++; end
            end
         end else if (op == DEL) begin
            if (!mem[cp][cid]) e = 1;
            else begin mem[cp][cid] = 0; occ[cp]--; end
         end else begin
            occ[cp] = 0;
            for (int i = 0; i < (1 << IDB); i++) mem[cp][i] = 0;
         end
      end
      if (rf) begin
         m_rsp_v = 1; m_port = rp; m_grant = g;
         if (g) m_gc = (m_gc < CMAX) ? m_gc + 1 : CMAX;
         else   m_dc = (m_dc < CMAX) ? m_dc + 1 : CMAX;
      end else if (rr) begin
         m_rsp_v = 0;
      end
      m_err = e;
      m_rdy = 1;
      @(posedge aclk);
      #1;
      chk_regs();
   endtask

   task automatic idle();
      cyc(0, ADD, 0, 0, 0, 0, 0, 1);
   endtask

   // Asynchronous reset between edges; outputs must clear before the next edge
   task automatic do_reset();
      #1;
      aresetn = 1'b0;
      #1;
      model_clear();
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk_regs();
      @(posedge aclk);
      #1;
      chk_regs();
      aresetn = 1'b1;
      idle();
   endtask

   initial begin
      model_clear();
      do_reset();

      // Empty table denies
      cyc(0, ADD, 0, 0, 1, 0, 5, 1);
      chk("t1 rsp_valid", 32'(rsp_valid), 32'd1);
      chk("t1 grant", 32'(rsp_grant), 32'd0);
      idle();
      chk("t1 deny_cnt", 32'(deny_cnt), 32'd1);
      chk("t1 grant_cnt", 32'(grant_cnt), 32'd0);

      // Simple grant, other port denies
      do_reset();
      cyc(1, ADD, 2, 9, 0, 0, 0, 1);
      cyc(0, ADD, 0, 0, 1, 2, 9, 1);
      chk("t2 grant", 32'(rsp_grant), 32'd1);
      chk("t2 port", 32'(rsp_port), 32'd2);
      cyc(0, ADD, 0, 0, 1, 1, 9, 1);
      chk("t2 deny", 32'(rsp_grant), 32'd0);
      idle();
      chk("t2 gcnt", 32'(grant_cnt), 32'd1);
      chk("t2 dcnt", 32'(deny_cnt), 32'd1);

      // Full row, error pulse, delete frees a slot
      do_reset();
      for (int i = 1; i <= 4; i++) cyc(1, ADD, 1, i, 0, 0, 0, 1);
      cyc(1, ADD, 1, 7, 0, 0, 0, 1);
      chk("t3 err pulse", 32'(ctrl_err), 32'd1);
      idle();
      chk("t3 err drop", 32'(ctrl_err), 32'd0);
      cyc(1, DEL, 1, 3, 0, 0, 0, 1);
      cyc(1, ADD, 1, 7, 0, 0, 0, 1);
      chk("t3 add ok", 32'(ctrl_err), 32'd0);
      cyc(0, ADD, 0, 0, 1, 1, 7, 1);
      chk("t3 grant 7", 32'(rsp_grant), 32'd1);
      cyc(0, ADD, 0, 0, 1, 1, 3, 1);
      chk("t3 deny 3", 32'(rsp_grant), 32'd0);

      // Same-cycle add and request sees the old table
      cyc(1, ADD, 0, 4, 1, 0, 4, 1);
      chk("t4 same cycle", 32'(rsp_grant), 32'd0);
      cyc(0, ADD, 0, 0, 1, 0, 4, 1);
      chk("t4 next cycle", 32'(rsp_grant), 32'd1);

      // Backpressure then back-to-back drain
      for (int i = 0; i < 5; i++) begin
         cyc(0, ADD, 0, 0, 1, 2, 2, 0);
         chk("t5 stall ready", 32'(req_ready), 32'd0);
         chk("t5 stall port", 32'(rsp_port), 32'd0);
      end
      for (int i = 0; i < 6; i++) cyc(0, ADD, 0, 0, 1, i % 4, i, 1);
      idle();

      // Saturation and mid-burst reset
      do_reset();
      for (int i = 0; i < 20; i++) cyc(0, ADD, 0, 0, 1, 3, 2, 1);
      idle();
      chk("t6 deny sat", 32'(deny_cnt), 32'd15);
      cyc(1, ADD, 2, 9, 0, 0, 0, 1);
      cyc(0, ADD, 0, 0, 1, 2, 9, 1);
      chk("t6 pre grant", 32'(rsp_grant), 32'd1);
      cyc(0, ADD, 0, 0, 1, 3, 1, 1);
      do_reset();
      cyc(0, ADD, 0, 0, 1, 2, 9, 1);
      chk("t6 post rst deny", 32'(rsp_grant), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         bit cv, rv, rr;
         logic [1:0] op;
         if ($urandom_range(199, 0) == 0) do_reset();
         cv = ($urandom_range(1, 0) == 1);
         op = ($urandom_range(15, 0) == 0) ? CLRA : 2'($urandom_range(2, 0));
         rv = ($urandom_range(9, 0) < 7);
         rr = ($urandom_range(3, 0) != 0);
         cyc(cv, op, int'($urandom_range(3, 0)), int'($urandom_range(5, 0)),
             rv, int'($urandom_range(3, 0)), int'($urandom_range(5, 0)), rr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/route_gate_rx.md
# route_gate_rx

Receive-side routing capability gate for the network VIU. It holds a host-programmed table of sender user-logic IDs permitted per destination port and checks each inbound route request against it. Each request gets one registered grant/deny response. Grant and deny events are counted for host telemetry. It sits between the network RX route-decode stage and the per-port user-logic demux.

## Interface
Parameters:
- N_PORTS, 4, number of destination ports; PORT_BITS = max(1, $clog2(N_PORTS))
- N_ENTRIES, 4, permitted sender IDs per port
- UL_ID_BITS, 4, sender user-logic ID width
- CNT_BITS, 16, width of grant/deny counters

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; asynchronous assertion, active-low
- ctrl_valid  in  1  host table command valid
- ctrl_ready  out  1  command accepted when ctrl_valid & ctrl_ready
- ctrl_op  in  2  00 ADD, 01 DEL, 10 CLR_PORT, 11 CLR_ALL
- ctrl_port  in  PORT_BITS  target port
- ctrl_ul_id  in  UL_ID_BITS  sender ID for ADD/DEL
- ctrl_err  out  1  one-cycle pulse: previous command failed
- req_valid  in  1  route request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_port  in  PORT_BITS  requested destination port
- req_ul_id  in  UL_ID_BITS  requesting sender ID
- rsp_valid  out  1  response valid
- rsp_ready  in  1  downstream accepts response
- rsp_port  out  PORT_BITS  echoed req_port
- rsp_grant  out  1  1 = permitted, 0 = dropped
- grant_cnt  out  CNT_BITS  saturating grant count
- deny_cnt  out  CNT_BITS  saturating deny count

## Operation
- Table: N_PORTS × N_ENTRIES slots. Each slot holds {valid, ul_id}. Reset clears every valid bit.
- ctrl_ready is 1 whenever out of reset. Commands complete in one cycle.
- ADD:
  - If ul_id is already valid in the port's row: no-op, no error.
  - Otherwise, write the lowest-index free slot.
  - If the row is full, or ctrl_port ≥ N_PORTS: no write, ctrl_err=1.
- DEL:
  - Invalidate every matching slot in the row.
  - If there is no match, or ctrl_port ≥ N_PORTS: ctrl_err=1.
- CLR_PORT: invalidate the whole row. Out-of-range port → ctrl_err=1.
- CLR_ALL: invalidate the whole table. Never errors.
- Lookup:
  - grant = req_port < N_PORTS AND some valid slot in row req_port equals req_ul_id.
  - Comparison is over all N_ENTRIES in parallel.
- Response register:
  - On a request handshake, load rsp_valid=1, rsp_port=req_port, rsp_grant=lookup.
  - rsp_valid clears on rsp_ready when no new request is accepted in the same cycle.
- req_ready = ~rsp_valid | rsp_ready. This gives full throughput, one request per cycle.
- Counters:
  - Each request handshake increments grant_cnt or deny_cnt.
  - Both counters saturate at 2^CNT_BITS−1 and never wrap.
  - CLR_ALL does not reset the counters; only aresetn does.

## Timing
- Reset values: ctrl_ready=0, ctrl_err=0, req_ready=0, rsp_valid=0, rsp_port=0, rsp_grant=0, grant_cnt=0, deny_cnt=0.
- Reset asserted mid-operation: everything above clears immediately and asynchronously. Any in-flight response is discarded. Table is cleared.
- Request latency: handshake in cycle N → rsp_valid/rsp_grant/rsp_port valid at cycle N+1. Held stable until rsp_ready.
- Backpressure: while rsp_valid & ~rsp_ready, req_ready=0. No request is lost or reordered.
- Table write from a ctrl handshake in cycle N is visible to lookups on requests accepted in cycle N+1 or later.
- Same-cycle ctrl and req: the lookup uses the pre-update table. Example: ADD in cycle N plus a matching request in cycle N → deny.
- ctrl_err asserts in cycle N+1 for a failing command in cycle N, for exactly one cycle.
- Counters update in cycle N+1 for a request accepted in cycle N, and track the response register load.

## Test plan
- Reset, then req port 0 / id 5 → rsp at +1 cycle, grant=0. deny_cnt=1, grant_cnt=0.
- ADD(port 2, id 9), then req(2,9) → grant=1, rsp_port=2. Then req(1,9) → grant=0. Counters end at 1/1.
- Fill port 1 with ids 1..4 (N_ENTRIES=4), then ADD(1,7) → ctrl_err pulse. Then DEL(1,3), ADD(1,7), req(1,7) → grant=1. Then req(1,3) → grant=0.
- Same-cycle ADD(0,4) and req(0,4) → grant=0. Repeat req(0,4) next cycle → grant=1.
- Hold rsp_ready=0 for 5 cycles with req_valid=1: req_ready=0, response stable. Release: back-to-back requests complete at 1 per cycle, in order.
- CNT_BITS=4: issue 20 denied requests → deny_cnt=15. Assert aresetn low mid-burst → all outputs zero that cycle, and a prior granted ID now denies.
